idu_exu_skid: RTL and testbench

//  Decode-to-execute pipeline register with a 2-entry skid buffer and a valid/ready handshake.

---
 rtl/idu_exu_skid.sv | 117 +++++++++++
 tb/tb_idu_exu_skid.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/idu_exu_skid.sv
// Decode-to-execute pipeline register with a 2-entry skid buffer.
// o_ready/o_valid come from registered state only, so there is no ready path from EXU back to IDU.
module idu_exu_skid #(
    parameter int W     = 64,
    parameter int SEL_W = 2,
    parameter int OPT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [W-1:0]     i_pc,
    input  logic [W-1:0]     i_rs1,
    input  logic [W-1:0]     i_rs2,
    input  logic [W-1:0]     i_imm,
    input  logic [SEL_W-1:0] i_exsrc,
    input  logic [OPT_W-1:0] i_exopt,
    input  logic [4:0]       i_rdid,
    input  logic             i_rdwen,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [W-1:0]     o_pc,
    output logic [W-1:0]     o_rs1,
    output logic [W-1:0]     o_rs2,
    output logic [W-1:0]     o_imm,
    output logic [SEL_W-1:0] o_exsrc,
    output logic [OPT_W-1:0] o_exopt,
    output logic [4:0]       o_rdid,
    output logic             o_rdwen
);
    localparam int BW = 4*W + SEL_W + OPT_W + 6;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] head, tail, in_bus;
    logic          in_fire, out_fire;
    logic          head_ld, head_from_tail, tail_ld;

    assign in_bus   = {i_pc, i_rs1, i_rs2, i_imm, i_exsrc, i_exopt, i_rdid, i_rdwen};
    assign in_fire  = i_valid & o_ready;
    assign out_fire = o_valid & i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= EMPTY;
        else       state <= state_nxt;
    end

    // Transition plus the data-register enables that belong to each transition.
    always_comb begin
        state_nxt      = EMPTY;
        head_ld        = 1'b0;
        head_from_tail = 1'b0;
        tail_ld        = 1'b0;
        case (state)
            EMPTY: begin
                state_nxt = EMPTY;
                if (in_fire) begin
                    head_ld   = 1'b1;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                state_nxt = ONE;
                if (in_fire && out_fire) begin
                    head_ld = 1'b1;
                end else if (in_fire) begin
                    tail_ld   = 1'b1;
                    state_nxt = FULL;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                state_nxt = FULL;
                if (out_fire) begin
                    head_from_tail = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Redirect kills held entries and the same-cycle input.
        if (i_flush) begin
            state_nxt      = EMPTY;
            head_ld        = 1'b0;
            head_from_tail = 1'b0;
            tail_ld        = 1'b0;
        end
    end

    always_comb begin
        o_valid = 1'b0;
        o_ready = 1'b0;
        case (state)
            EMPTY: begin o_valid = 1'b0; o_ready = 1'b1; end
            ONE:   begin o_valid = 1'b1; o_ready = 1'b1; end
            FULL:  begin o_valid = 1'b1; o_ready = 1'b0; end
            default: begin o_valid = 1'b0; o_ready = 1'b0; end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (head_ld)             head <= in_bus;
            else if (head_from_tail) head <= tail;
            if (tail_ld)             tail <= in_bus;
        end
    end

    assign {o_pc, o_rs1, o_rs2, o_imm, o_exsrc, o_exopt, o_rdid, o_rdwen} = head;

endmodule

// File: tb/tb_idu_exu_skid.sv
// Bench for idu_exu_skid: directed vector table, pre-edge handshake checks,
// then random valid/ready/flush traffic against a queue-based FIFO model.
module tb_idu_exu_skid;
    localparam int W  = 64;
    localparam int BW = 4*W + 2 + 5 + 6;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1, i_flush = 1'b0, i_valid = 1'b0, i_ready = 1'b0;
    logic [W-1:0]  i_pc = '0, i_rs1 = '0, i_rs2 = '0, i_imm = '0;
    logic [1:0]    i_exsrc = '0;
    logic [4:0]    i_exopt = '0, i_rdid = '0;
    logic          i_rdwen = 1'b0;
    logic          o_ready, o_valid, o_rdwen;
    logic [W-1:0]  o_pc, o_rs1, o_rs2, o_imm;
    logic [1:0]    o_exsrc;
    logic [4:0]    o_exopt, o_rdid;
    logic [BW-1:0] in_bus, out_bus;

    int nvec = 0;
    int nerr = 0;

    idu_exu_skid #(.W(W), .SEL_W(2), .OPT_W(5)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
        .i_pc(i_pc), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm), .i_exsrc(i_exsrc),
        .i_exopt(i_exopt), .i_rdid(i_rdid), .i_rdwen(i_rdwen), .o_valid(o_valid),
        .i_ready(i_ready), .o_pc(o_pc), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_imm(o_imm),
        .o_exsrc(o_exsrc), .o_exopt(o_exopt), .o_rdid(o_rdid), .o_rdwen(o_rdwen)
    );

    always #5 clk = ~clk;

    assign in_bus  = {i_pc, i_rs1, i_rs2, i_imm, i_exsrc, i_exopt, i_rdid, i_rdwen};
    assign out_bus = {o_pc, o_rs1, o_rs2, o_imm, o_exsrc, o_exopt, o_rdid, o_rdwen};

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          rst, flush, valid, ready;
        logic [W-1:0]  pc;
        logic          exp_valid, exp_ready, chk_pc;
        logic [W-1:0]  exp_pc;
        string         name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm, input logic r, input logic f, input logic v,
                                input logic [W-1:0] pc, input logic rdy, input logic ev,
                                input logic er, input logic cp, input logic [W-1:0] epc);
        vec_t t;
        t.name = nm; t.rst = r; t.flush = f; t.valid = v; t.pc = pc; t.ready = rdy;
        t.exp_valid = ev; t.exp_ready = er; t.chk_pc = cp; t.exp_pc = epc;
        return t;
    endfunction

    // Side fields are derived from pc so field swaps show up in the random phase too.
    task automatic drive_pc(input logic [W-1:0] pc);
        i_pc = pc; i_rs1 = ~pc; i_rs2 = pc ^ 64'h5555_5555_5555_5555; i_imm = pc + 64'd1;
        i_exsrc = pc[3:2]; i_exopt = pc[8:4]; i_rdid = pc[6:2]; i_rdwen = pc[2];
    endtask

    logic [BW-1:0] q[$];
    logic [BW-1:0] prev_out;
    logic          prev_stall;
    logic          mfire_in, mfire_out;

    initial begin
        //              name        rst flu val pc              rdy  ev er cp exp_pc
        vecs.push_back(mk("reset",     1, 0, 0, 64'h0,          0,   0, 1, 1, 64'h0));
        vecs.push_back(mk("first",     0, 0, 1, 64'h8000_0000,  1,   1, 1, 1, 64'h8000_0000));
        vecs.push_back(mk("drain1",    0, 0, 0, 64'h0,          1,   0, 1, 0, 64'h0));
        vecs.push_back(mk("strm0",     0, 0, 1, 64'h0,          1,   1, 1, 1, 64'h0));
        vecs.push_back(mk("strm4",     0, 0, 1, 64'h4,          1,   1, 1, 1, 64'h4));
        vecs.push_back(mk("strm8",     0, 0, 1, 64'h8,          1,   1, 1, 1, 64'h8));
        vecs.push_back(mk("strmC",     0, 0, 1, 64'hC,          1,   1, 1, 1, 64'hC));
        vecs.push_back(mk("strm_end",  0, 0, 0, 64'h0,          1,   0, 1, 0, 64'h0));
        vecs.push_back(mk("bp10",      0, 0, 1, 64'h10,         0,   1, 1, 1, 64'h10));
        vecs.push_back(mk("bp14",      0, 0, 1, 64'h14,         0,   1, 0, 1, 64'h10));
        vecs.push_back(mk("bp18_held", 0, 0, 1, 64'h18,         0,   1, 0, 1, 64'h10));
        vecs.push_back(mk("bp_out14",  0, 0, 1, 64'h18,         1,   1, 1, 1, 64'h14));
        vecs.push_back(mk("bp_out18",  0, 0, 1, 64'h18,         1,   1, 1, 1, 64'h18));
        vecs.push_back(mk("bp_end",    0, 0, 0, 64'h0,          1,   0, 1, 0, 64'h0));
        vecs.push_back(mk("fl30",      0, 0, 1, 64'h30,         0,   1, 1, 1, 64'h30));
        vecs.push_back(mk("fl34",      0, 0, 1, 64'h34,         0,   1, 0, 1, 64'h30));
        vecs.push_back(mk("flush",     0, 1, 1, 64'h20,         0,   0, 1, 0, 64'h0));
        vecs.push_back(mk("fl_after",  0, 0, 0, 64'h0,          1,   0, 1, 0, 64'h0));
        vecs.push_back(mk("rs40",      0, 0, 1, 64'h40,         0,   1, 1, 1, 64'h40));
        vecs.push_back(mk("rs44",      0, 0, 1, 64'h44,         0,   1, 0, 1, 64'h40));
        vecs.push_back(mk("rst_full",  1, 0, 0, 64'h0,          0,   0, 1, 1, 64'h0));
        vecs.push_back(mk("rst_after", 0, 0, 0, 64'h0,          1,   0, 1, 1, 64'h0));
        vecs.push_back(mk("rst_flush", 1, 1, 1, 64'h60,         1,   0, 1, 1, 64'h0));

        foreach (vecs[k]) begin
            @(negedge clk);
            i_rst = vecs[k].rst; i_flush = vecs[k].flush; i_valid = vecs[k].valid;
            i_ready = vecs[k].ready; drive_pc(vecs[k].pc);
            @(posedge clk); #1;
            chk({vecs[k].name, "_valid"}, BW'(o_valid), BW'(vecs[k].exp_valid));
            chk({vecs[k].name, "_ready"}, BW'(o_ready), BW'(vecs[k].exp_ready));
            if (vecs[k].chk_pc) chk({vecs[k].name, "_pc"}, BW'(o_pc), BW'(vecs[k].exp_pc));
        end

        // Handshake outputs must not react combinationally to i_valid / i_ready.
        @(negedge clk);
        i_rst = 0; i_flush = 0; i_valid = 1; i_ready = 0; drive_pc(64'h50);
        #1 chk("comb_valid", BW'(o_valid), BW'(1'b0));
        @(negedge clk); drive_pc(64'h54);
        @(negedge clk); i_valid = 0; i_ready = 1;
        #1 chk("comb_ready", BW'(o_ready), BW'(1'b0));
        chk("full_valid", BW'(o_valid), BW'(1'b1));
        @(negedge clk);
        #1 chk("skid_pc", BW'(o_pc), BW'(64'h54));
        @(negedge clk);
        #1 chk("drained", BW'(o_valid), BW'(1'b0));

        // Random traffic: model is a plain FIFO of at most two bundles.
        q.delete();
        prev_stall = 1'b0;
        prev_out   = '0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            i_valid = ($urandom_range(3) != 0);
            i_ready = ($urandom_range(2) != 0);
            i_flush = ($urandom_range(63) == 0);
            i_pc = {$urandom, $urandom}; i_rs1 = {$urandom, $urandom};
            i_rs2 = {$urandom, $urandom}; i_imm = {$urandom, $urandom};
            i_exsrc = 2'($urandom); i_exopt = 5'($urandom);
            i_rdid = 5'($urandom); i_rdwen = 1'($urandom);
            #1;
            chk("rnd_valid", BW'(o_valid), BW'(q.size() > 0));
            chk("rnd_ready", BW'(o_ready), BW'(q.size() < 2));
            if (q.size() > 0) chk("rnd_data", out_bus, q[0]);
            if (prev_stall) chk("rnd_stall_hold", out_bus, prev_out);
            mfire_in  = i_valid && (q.size() < 2);
            mfire_out = i_ready && (q.size() > 0);
            prev_stall = (q.size() > 0) && !i_ready && !i_flush;
            prev_out   = out_bus;
            if (i_flush) q.delete();
            else begin
                if (mfire_out) void'(q.pop_front());
                if (mfire_in)  q.push_back(in_bus);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
